// File: rtl/spi_ram_multi.sv
// Command-decoded single-port RAM behind an SPI slave: write/read pointers, a RD_LATENCY-deep
// read pipeline and a sticky out-of-range flag. Define SPI_RAM_AUTO_INC_EN for pointer auto-increment.
module spi_ram_multi #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH+1:0] din,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  err
);

    localparam int STAGES = RD_LATENCY - 1;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        CMD_WADDR = 2'b00,
        CMD_WDATA = 2'b01,
        CMD_RADDR = 2'b10,
        CMD_RDATA = 2'b11
    } cmd_e;

    cmd_e                  cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic                  wr_ok, rd_ok, wr_fire, rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:0][DATA_WIDTH-1:0] data_pipe;

    assign cmd     = cmd_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload = din[DATA_WIDTH-1:0];
    assign addr_in = payload[ADDR_WIDTH-1:0];
    assign wr_ok   = {1'b0, wr_addr} < DEPTH;
    assign rd_ok   = {1'b0, rd_addr} < DEPTH;
    assign wr_fire = rx_valid && (cmd == CMD_WDATA);
    assign rd_fire = rx_valid && (cmd == CMD_RDATA);
    assign rd_word = rd_ok ? mem[rd_addr[IDX_W-1:0]] : '0;

    // Wrap to 0 past the last word; an out-of-range pointer also lands on 0.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        logic [ADDR_WIDTH:0] n;
        n = {1'b0, p} + (ADDR_WIDTH+1)'(1);
        return (n >= DEPTH) ? '0 : n[ADDR_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (rx_valid) begin
            case (cmd)
                CMD_WADDR: wr_addr <= addr_in;
                CMD_RADDR: rd_addr <= addr_in;
`ifdef SPI_RAM_AUTO_INC_EN
                CMD_WDATA: wr_addr <= next_ptr(wr_addr);
                CMD_RDATA: rd_addr <= next_ptr(rd_addr);
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if ((wr_fire && !wr_ok) || (rd_fire && !rd_ok))
            err <= 1'b1;
    end

    // Memory has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_ok)
            mem[wr_addr[IDX_W-1:0]] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_fire;
            if (rd_fire)
                data_pipe[0] <= rd_word;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1])
                    data_pipe[k] <= data_pipe[k-1];
            end
        end
    end

    // Stages load only behind a valid, so dout holds the last read between pulses.
    assign dout     = data_pipe[STAGES];
    assign tx_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_spi_ram_multi.sv
// Scoreboard bench: two instances (256 words/latency 1 and 200 words/latency 2) share one
// randomized command stream; a behavioural model predicts every read pulse and the err flag.
module tb_spi_ram_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout_a, dout_b;
    logic       tx_a, tx_b, err_a, err_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] mm [2][256];
    int         wa [2];
    int         ra [2];
    bit         merr [2];
    int         dep [2] = '{256, 200};
    int         lat [2] = '{1, 2};

    spi_ram_multi #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_a), .tx_valid(tx_a), .err(err_a));

    spi_ram_multi #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .RD_LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_b), .tx_valid(tx_b), .err(err_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bump(input int a, input int d);
`ifdef SPI_RAM_AUTO_INC_EN
        return (a + 1 >= d) ? 0 : a + 1;
`else
        return a;
`endif
    endfunction

    task automatic model(input logic [1:0] c, input logic [7:0] p);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            case (c)
                2'd0: wa[i] = int'(p);
                2'd1: begin
                    if (wa[i] < dep[i]) mm[i][wa[i]] = p;
                    else merr[i] = 1'b1;
                    wa[i] = bump(wa[i], dep[i]);
                end
                2'd2: ra[i] = int'(p);
                default: begin
                    e.d   = (ra[i] < dep[i]) ? mm[i][ra[i]] : 8'h00;
                    e.due = cyc + lat[i];
                    if (ra[i] >= dep[i]) merr[i] = 1'b1;
                    if (i == 0) qa.push_back(e);
                    else qb.push_back(e);
                    ra[i] = bump(ra[i], dep[i]);
                end
            endcase
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            wa[i] = 0; ra[i] = 0; merr[i] = 1'b0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p, input bit v);
        @(negedge clk);
        din      = {c, p};
        rx_valid = v;
        if (v) model(c, p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic check_err(input string nm);
        idle(3);
        chk({nm, "_err_a"}, 32'(err_a), 32'(merr[0]));
        chk({nm, "_err_b"}, 32'(err_b), 32'(merr[1]));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_dout_a", 32'(dout_a), 0);
        chk("rst_tx_a",   32'(tx_a),   0);
        chk("rst_err_a",  32'(err_a),  0);
        chk("rst_dout_b", 32'(dout_b), 0);
        chk("rst_tx_b",   32'(tx_b),   0);
        chk("rst_err_b",  32'(err_b),  0);
        rst_n = 1'b1;
    endtask

    // Flag overdue expectations, then match any pulse against the oldest one.
    task automatic mon(input int i, input logic tv, input logic [7:0] d);
        exp_t e;
        int   n;
        n = (i == 0) ? qa.size() : qb.size();
        while (n > 0) begin
            e = (i == 0) ? qa[0] : qb[0];
            if (e.due >= cyc) break;
            total++; bad++;
            $display("FAIL missing_pulse dut%0d: expected data %0h due cycle %0d, now %0d", i, e.d, e.due, cyc);
            if (i == 0) void'(qa.pop_front());
            else void'(qb.pop_front());
            n--;
        end
        if (tv !== 1'b1) return;
        total++;
        if (n == 0) begin
            bad++;
            $display("FAIL unexpected_pulse dut%0d: got dout %0h with nothing expected (cycle %0d)", i, d, cyc);
            return;
        end
        e = (i == 0) ? qa.pop_front() : qb.pop_front();
        if (d !== e.d || cyc != e.due) begin
            bad++;
            $display("FAIL read_data dut%0d: got %0h at cycle %0d, expected %0h at cycle %0d", i, d, cyc, e.d, e.due);
        end
    endtask

    always @(negedge clk) begin
        mon(0, tx_a, dout_a);
        mon(1, tx_b, dout_b);
    end

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Give every word a known value; the memory survives the reset that follows.
        for (int a = 0; a < 256; a++) begin
            send(2'd0, 8'(a), 1'b1);
            send(2'd1, 8'($urandom_range(0, 255)), 1'b1);
        end
        idle(3);
        reset_pulse();

        // Write then read back; second pair reads two addresses in order.
        send(2'd0, 8'h05, 1'b1); send(2'd1, 8'hBB, 1'b1);
        send(2'd2, 8'h05, 1'b1); send(2'd3, 8'h00, 1'b1);
        send(2'd0, 8'h06, 1'b1); send(2'd1, 8'hCC, 1'b1);
        send(2'd2, 8'h05, 1'b1); send(2'd3, 8'h00, 1'b1);
        send(2'd2, 8'h06, 1'b1); send(2'd3, 8'h00, 1'b1);
        check_err("basic");

        // Inactive cycles carrying commands must change nothing.
        send(2'd3, 8'h05, 1'b0); send(2'd1, 8'h77, 1'b0); send(2'd0, 8'h10, 1'b0);
        send(2'd3, 8'h00, 1'b1); send(2'd3, 8'h00, 1'b1);
        idle(2);

        // Address 0xC8 is out of range only for the 200-word instance.
        send(2'd0, 8'hC8, 1'b1); send(2'd1, 8'h11, 1'b1);
        send(2'd2, 8'hC8, 1'b1); send(2'd3, 8'h00, 1'b1);
        check_err("oob");
        send(2'd2, 8'h05, 1'b1); send(2'd3, 8'h00, 1'b1);
        check_err("sticky");
        reset_pulse();

        // Wrap across the top of the 256-word space.
        send(2'd0, 8'hFF, 1'b1); send(2'd1, 8'hA1, 1'b1); send(2'd1, 8'hA2, 1'b1);
        send(2'd2, 8'hFF, 1'b1); send(2'd3, 8'h00, 1'b1); send(2'd3, 8'h00, 1'b1);
        check_err("wrap");
        reset_pulse();

        // Reset lands while the latency-2 read is still in flight.
        @(negedge clk);
        din      = {2'd3, 8'h00};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("inflight_tx_b",   32'(tx_b),   0);
        chk("inflight_dout_b", 32'(dout_b), 0);
        chk("inflight_tx_a",   32'(tx_a),   0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        for (int n = 0; n < 3000; n++)
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
        check_err("random");

        idle(6);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
